timer_apb_regs: RTL

TIMER_APB_REGS -- requirements
Module: timer_apb_regs

---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_apb_regs.sv | 118 +++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer register block: bus address map,
// TCR field positions, writable-bit mask and APB slave FSM encoding.
package timer_pkg;

    // Register byte addresses
    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;

    // TCR field positions as seen by the counter block
    localparam int unsigned TCR_LOAD_BIT   = 7;
    localparam int unsigned TCR_UPDOWN_BIT = 5;
    localparam int unsigned TCR_EN_BIT     = 4;
    localparam int unsigned TCR_CKS_MSB    = 1;
    localparam int unsigned TCR_CKS_LSB    = 0;

    // Only load, updown, en and cks are implemented; bits 6,3,2 are reserved
    localparam logic [7:0] TCR_WR_MASK = 8'hB3;

    // TSR flag positions
    localparam int unsigned TSR_OVF_BIT = 0;
    localparam int unsigned TSR_UDF_BIT = 1;

    // APB slave FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage : timer_pkg

// File: rtl/timer_apb_regs.sv
// APB register front end of the timer: holds TDR/TCR/TSR, inserts a fixed
// number of wait states per access and flags accesses beyond TSR as errors.
module timer_apb_regs
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1   // legal range 0..3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic [7:0] tdr,
    output logic [7:0] tcr,
    input  logic       ovf_set,
    input  logic       udf_set,
    output logic [1:0] tsr
);

    localparam logic [1:0] WS = WAIT_STATES[1:0];

    apb_state_e state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic [1:0] tsr_q, tsr_d;

    logic       addr_err;
    logic       wr_en;
    logic [7:0] rdata;

    // Completion only while still selected, so an aborted access never completes
    assign pready   = (state_q == ST_ACCESS) && psel && (wait_q == WS);
    assign addr_err = (paddr > ADDR_TSR);
    assign pslverr  = pready && addr_err;
    assign wr_en    = psel && penable && pwrite && pready && !addr_err;

    // FSM next state and wait-state counting
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            ST_IDLE:   if (psel && !penable) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;                     // abort
                end else if (pready) begin
                    state_d = !penable ? ST_SETUP : ST_IDLE;
                end else begin
                    wait_d  = wait_q + 2'd1;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Register write decode and status flag set/clear
    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        tsr_d = tsr_q;
        if (wr_en) begin
            unique case (paddr)
                ADDR_TDR: tdr_d = pwdata;
                ADDR_TCR: tcr_d = pwdata & TCR_WR_MASK;
                ADDR_TSR: tsr_d = tsr_q & pwdata[1:0];   // write 0 clears
                default:  ;
            endcase
        end
        // Hardware set has priority over a same-cycle software clear
        tsr_d[TSR_OVF_BIT] = tsr_d[TSR_OVF_BIT] | ovf_set;
        tsr_d[TSR_UDF_BIT] = tsr_d[TSR_UDF_BIT] | udf_set;
    end

    // Read mux; data is driven only in the completing cycle
    always_comb begin
        rdata = 8'h00;
        unique case (paddr)
            ADDR_TDR: rdata = tdr_q;
            ADDR_TCR: rdata = tcr_q;
            ADDR_TSR: rdata = {6'b0, tsr_q};
            default:  rdata = 8'h00;
        endcase
        prdata = pready ? rdata : 8'h00;
    end

    // State and register flops
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            tdr_q   <= 8'h00;
            tcr_q   <= 8'h00;
            tsr_q   <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values regardless of statement order.
            state_q <= state_d;
            wait_q  <= wait_d;
            tdr_q   <= tdr_d;
            tcr_q   <= tcr_d;
            tsr_q   <= tsr_d;
        end
    end

    assign tdr = tdr_q;
    assign tcr = tcr_q;
    assign tsr = tsr_q;

endmodule : timer_apb_regs
